// File: rtl/fifo_lvl.sv
// Synchronous first-word-fall-through FIFO with an occupancy count, programmable
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module fifo_lvl #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  localparam int PTR_BITS = $clog2(DEPTH),
  localparam int CNT_BITS = PTR_BITS + 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                clr,
  input  logic [WIDTH-1:0]    din,
  input  logic                w,
  input  logic                r,
  output logic [WIDTH-1:0]    dout,
  input  logic [CNT_BITS-1:0] af_thr,
  input  logic [CNT_BITS-1:0] ae_thr,
  output logic [CNT_BITS-1:0] level,
  output logic                full,
  output logic                empty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic                overflow,
  output logic                underflow
);

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [PTR_BITS-1:0] wptr;
  logic [PTR_BITS-1:0] rptr;
  logic                push;
  logic                pop;

  assign full  = (level == CNT_BITS'(DEPTH));
  assign empty = (level == '0);

  // A write into a full FIFO still succeeds when the same edge pops a word.
  assign push = w & (~full | r);
  assign pop  = r & ~empty;

  assign almost_full  = (level >= af_thr);
  assign almost_empty = (level <= ae_thr);

  assign dout = mem[rptr];

  // Storage carries no reset; contents are only meaningful below level.
  always_ff @(posedge clk) begin
    if (push && !clr) begin
      mem[wptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr      <= '0;
      rptr      <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      wptr      <= '0;
      rptr      <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + PTR_BITS'(1);
      end
      if (pop) begin
        rptr <= rptr + PTR_BITS'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + CNT_BITS'(1);
        2'b01:   level <= level - CNT_BITS'(1);
        default: level <= level;
      endcase
      if (w && full && !r) begin
        overflow <= 1'b1;
      end
      if (r && empty) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule
